data_mem_ctrl: RTL
==================

# data_mem_ctrl

Downstream memory stage of the single-cycle MIPS core. It takes the datapath's ALU result as a byte address, the store data and the controller's memread/memwrite strobes. It runs a multi-cycle valid/ready transaction on a word-addressed data bus and returns load data to the result mux. While an access is in flight it holds `stall` high; the core gates its PC register and register-file writes with `stall`.

## Interface
- `TIMEOUT`, default 255: max cycles an access may spend in REQ+WAIT before it is aborted; legal range 2..65535.
- `clk`  in  1  system clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-high.
- `memread`  in  1  load strobe from controller.
- `memwrite`  in  1  store strobe from controller; wins if both are high (access is a write).
- `addr`  in  32  byte address (datapath ALU output).
- `writedata`  in  32  store data.
- `readdata`  out  32  registered load data to the result mux.
- `stall`  out  1  combinational; freezes the core while high.
- `bus_req`  out  1  registered request valid.
- `bus_we`  out  1  registered; 1 = write.
- `bus_addr`  out  30  registered word address, `addr[31:2]`.
- `bus_wdata`  out  32  registered write data.
- `bus_ready`  in  1  bus accepts the request this cycle.
- `bus_rvalid`  in  1  read data valid.
- `bus_rdata`  in  32  read data.
- `misaligned_err`  out  1  sticky; cleared only by reset.
- `timeout_err`  out  1  sticky; cleared only by reset.

## Operation
- States: IDLE, REQ, WAIT, DONE. Reset enters IDLE.
- Define `acc = memread | memwrite` and `aligned = (addr[1:0] == 0)`.
- IDLE:
  - `stall = acc & aligned`.
  - If `acc & aligned`: latch `addr[31:2]`, `writedata` and `we = memwrite` into the bus registers, then go to REQ.
  - If `acc & ~aligned`: do not start an access, keep `stall` at 0, set `misaligned_err`, leave `readdata` unchanged and stay in IDLE.
- REQ:
  - `bus_req = 1`, `stall = 1`. `bus_addr`, `bus_we` and `bus_wdata` stay stable until the handshake.
  - On `bus_ready`, drop `bus_req`. A write goes to DONE; a read goes to WAIT.
  - `bus_rvalid` is ignored in REQ.
- WAIT:
  - `stall = 1`.
  - On `bus_rvalid`, load `readdata <= bus_rdata` and go to DONE.
- DONE:
  - `stall = 0` for exactly one cycle, so the instruction commits. Then go unconditionally to IDLE.
  - DONE never starts a new access. The strobes still belong to the committing instruction.
- Timeout:
  - A counter of width $clog2(TIMEOUT+1) clears on entry to REQ and increments every REQ/WAIT cycle.
  - When the access has spent TIMEOUT cycles in REQ+WAIT without completing, abort it. Drop `bus_req`, set `readdata <= 0` for reads, set `timeout_err` and go to DONE.
  - The abort has priority over a `bus_ready`/`bus_rvalid` arriving in the same cycle.
- Reset mid-access: asynchronously return to IDLE with `bus_req = 0` immediately. Any late `bus_rvalid` is ignored.

## Timing
- Reset values:
  - `readdata` = 0, `bus_req` = 0, `bus_we` = 0, `bus_addr` = 0, `bus_wdata` = 0.
  - `misaligned_err` = 0, `timeout_err` = 0.
  - `stall` follows the IDLE equation.
- Read with zero bus wait: cycle0 IDLE (stall=1), cycle1 REQ (ready=1), cycle2 WAIT (rvalid=1), cycle3 DONE (stall=0, `readdata` valid). That is 3 stall cycles.
- Write with zero bus wait: cycle0 IDLE, cycle1 REQ (ready=1), cycle2 DONE. That is 2 stall cycles.
- Each bus wait cycle adds exactly one stall cycle.
- Back-to-back memory instructions: the second one is seen in IDLE on the cycle after DONE.
- Non-memory instructions: `stall = 0` with zero added latency.
- `readdata` changes only on `bus_rvalid` in WAIT, on a read timeout, or on reset.

## Test plan
- Aligned read: `addr`=0x0000_0104, memread=1, ready at cycle1, rvalid at cycle2 with rdata=0xCAFE_F00D -> `bus_addr`=0x41, `bus_we`=0, stall=1,1,1,0, `readdata`=0xCAFEF00D at cycle3.
- Aligned write with 2 wait cycles: `addr`=0x20, writedata=0x1234_5678 -> `bus_req` high 3 cycles with stable `bus_addr`=0x8 and `bus_wdata`; stall high 4 cycles, then DONE.
- Misaligned read: `addr`=0x0000_0003 -> no `bus_req`, stall=0, `misaligned_err`=1 from the next cycle, `readdata` unchanged.
- Timeout with TIMEOUT=8 and `bus_ready` held 0 -> `bus_req` high exactly 8 cycles, then DONE, `timeout_err`=1, `readdata`=0. Repeat with `bus_ready` rising in the 8th cycle -> abort still wins.
- Reset asserted during WAIT, then `bus_rvalid` pulsed -> `bus_req`=0 immediately, state IDLE, `readdata`=0, no capture.
- memread=memwrite=1 at aligned `addr`=0x40 -> treated as write, `bus_we`=1, 2-cycle stall with immediate ready.

Source files
------------

// File: rtl/data_mem_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | data_mem_ctrl: memory stage bridging the core's load/store strobes to a    |
// | multi-cycle valid/ready word bus; stalls the core while an access runs.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module data_mem_ctrl #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [31:0] addr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        stall,
  output logic        bus_req,
  output logic        bus_we,
  output logic [29:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ready,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata,
  output logic        misaligned_err,
  output logic        timeout_err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] c_limit = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          w_acc;
  logic          w_aligned;
  logic          w_expire;

  assign w_acc     = memread | memwrite;
  assign w_aligned = (addr[1:0] == 2'b00);
  // r_cnt holds the number of REQ/WAIT cycles already completed, so the
  // TIMEOUT-th cycle is the one where it reads TIMEOUT-1.
  assign w_expire  = (r_cnt == c_limit);

  always_comb begin
    stall = 1'b0;
    case (r_state)
      S_IDLE:  stall = w_acc & w_aligned;
      S_REQ:   stall = 1'b1;
      S_WAIT:  stall = 1'b1;
      S_DONE:  stall = 1'b0;
      default: stall = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      readdata       <= 32'd0;
      bus_req        <= 1'b0;
      bus_we         <= 1'b0;
      bus_addr       <= 30'd0;
      bus_wdata      <= 32'd0;
      misaligned_err <= 1'b0;
      timeout_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_acc && w_aligned) begin
            bus_addr  <= addr[31:2];
            bus_wdata <= writedata;
            bus_we    <= memwrite;
            bus_req   <= 1'b1;
            r_cnt     <= '0;
            r_state   <= S_REQ;
          end else if (w_acc) begin
            misaligned_err <= 1'b1;
          end
        end
        S_REQ: begin
          r_cnt <= r_cnt + CW'(1);
          if (w_expire) begin
            bus_req     <= 1'b0;
            timeout_err <= 1'b1;
            if (!bus_we) readdata <= 32'd0;
            r_state     <= S_DONE;
          end else if (bus_ready) begin
            bus_req <= 1'b0;
            r_state <= bus_we ? S_DONE : S_WAIT;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt + CW'(1);
          if (w_expire) begin
            timeout_err <= 1'b1;
            readdata    <= 32'd0;
            r_state     <= S_DONE;
          end else if (bus_rvalid) begin
            readdata <= bus_rdata;
            r_state  <= S_DONE;
          end
        end
        S_DONE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
